// File: rtl/uart_nec_frame_parser.sv
// rtl/uart_nec_frame_parser.sv - assembles 5-byte NEC frames (sync, addr, ~addr, cmd, ~cmd)
// from a UART byte stream, checks complements and inter-byte timeout.
module uart_nec_frame_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 37500,
  parameter int         TW        = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_addr,
  output logic [7:0] o_cmd,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy,
  output logic [7:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_ADDR,
    GET_NADDR,
    GET_CMD,
    GET_NCMD
  } state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_addr_b;
  logic [7:0]    r_naddr_b;
  logic [7:0]    r_cmd_b;

  logic w_collect;
  logic w_tmo;
  logic w_addr_ok;
  logic w_cmd_ok;

  assign w_collect = (r_state != WAIT_SYNC);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo     = w_collect && !i_rx_valid && (r_tmo_cnt == TMO_LAST);
  assign w_addr_ok = ((r_addr_b ^ r_naddr_b) == 8'hFF);
  assign w_cmd_ok  = ((r_cmd_b ^ i_rx_data) == 8'hFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= WAIT_SYNC;
      r_tmo_cnt     <= '0;
      r_addr_b      <= 8'h00;
      r_naddr_b     <= 8'h00;
      r_cmd_b       <= 8'h00;
      o_addr        <= 8'h00;
      o_cmd         <= 8'h00;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_err_code    <= 2'b00;
      o_busy        <= 1'b0;
      o_frame_cnt   <= 8'h00;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;

      if (!w_collect || i_rx_valid || w_tmo) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      case (r_state)
        WAIT_SYNC: begin
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            r_state <= GET_ADDR;
            o_busy  <= 1'b1;
          end
        end
        GET_ADDR: begin
          if (i_rx_valid) begin
            r_addr_b <= i_rx_data;
            r_state  <= GET_NADDR;
          end
        end
        GET_NADDR: begin
          if (i_rx_valid) begin
            r_naddr_b <= i_rx_data;
            r_state   <= GET_CMD;
          end
        end
        GET_CMD: begin
          if (i_rx_valid) begin
            r_cmd_b <= i_rx_data;
            r_state <= GET_NCMD;
          end
        end
        GET_NCMD: begin
          if (i_rx_valid) begin
            r_state <= WAIT_SYNC;
            o_busy  <= 1'b0;
            if (!w_addr_ok) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 2'b01;
            end else if (!w_cmd_ok) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 2'b10;
            end else begin
              o_frame_valid <= 1'b1;
              o_addr        <= r_addr_b;
              o_cmd         <= r_cmd_b;
              o_frame_cnt   <= o_frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= WAIT_SYNC;
          o_busy  <= 1'b0;
        end
      endcase

      if (w_tmo) begin
        r_state     <= WAIT_SYNC;
        o_busy      <= 1'b0;
        o_frame_err <= 1'b1;
        o_err_code  <= 2'b11;
      end
    end
  end

endmodule
